// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg
//   Shared types and constants for the 4-requester round-robin mux arbiter.
//   No ports; imported by the interface, the picker and the top.
package mux4_rr_arbiter_pkg;

    localparam int SEL_W = 2;
    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if
//   Bundles the requester/downstream side of the arbiter.
//   req, din0..din3, out_ready : driven by the requesters / downstream (master)
//   gnt, sel, dout, dout_valid : driven by the arbiter (slave)
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    import mux4_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic             out_ready;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    modport master (
        output req, din0, din1, din2, din3, out_ready,
        input  gnt, sel, dout, dout_valid
    );

    modport slave (
        input  req, din0, din1, din2, din3, out_ready,
        output gnt, sel, dout, dout_valid
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4
//   Combinational round-robin picker.
//   req[3:0]    : pending requests
//   last[1:0]   : previous winner; the scan starts just after it
//   winner[1:0] : first set request in order last+1, +2, +3, +4 (mod 4)
//   any         : at least one request pending
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down to the nearest so the nearest set
    // request overwrites earlier hits. Offset 4 wraps to 'last' itself.
    always_comb begin
        winner = last;
        any    = 1'b0;
        cand   = last;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter owning the select of a 4:1 data mux. A grant lasts
//   until MAX_BURST beats have transferred or the owner drops its request,
//   then one IDLE cycle is inserted before the next grant.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of mux4_rr_arbiter_if (req/din/out_ready in,
//           gnt/sel/dout/dout_valid out)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no owner; gnt=0; arbitrate among req for the next cycle
//   ST_GRANT | sel_q owns the output; beats counted in cnt_q
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [SEL_W-1:0] pick;
    logic             pick_any;
    logic             granted;
    logic             req_sel;
    logic             xfer;
    logic [WIDTH-1:0] dmux;

    rr_pick4 u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (pick),
        .any    (pick_any)
    );

    assign granted = (state_q == ST_GRANT);
    assign req_sel = bus.req[sel_q];
    assign xfer    = granted & req_sel & bus.out_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick;
                    gnt_d   = onehot4(pick);
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request means no beat was offered, so the two
                // exit conditions can never double-count a transfer.
                if (!req_sel || (xfer && (cnt_inc == CNT_W'(MAX_BURST)))) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    last_d  = sel_q;
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        dmux = bus.din0;
        case (sel_q)
            2'd0: dmux = bus.din0;
            2'd1: dmux = bus.din1;
            2'd2: dmux = bus.din2;
            2'd3: dmux = bus.din3;
            default: dmux = bus.din0;
        endcase
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.dout_valid = granted & req_sel;
    assign bus.dout       = granted ? dmux : '0;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 multiplexed output channel among four requesters using round-robin arbitration.
- Drives the 2-bit mux select and a one-hot grant.
- Holds a grant for a burst of up to MAX_BURST beats, then re-arbitrates.
- Sits in front of the 4x1 mux datapath and owns its select lines, which software and other logic never drive directly.

Parameters:
- WIDTH, 8, data width of each requester input and of the output.
- MAX_BURST, 4, maximum beats transferred per grant (range 1..255).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  4  request per requester; bit i = requester i.
- din0  input  WIDTH  data from requester 0.
- din1  input  WIDTH  data from requester 1.
- din2  input  WIDTH  data from requester 2.
- din3  input  WIDTH  data from requester 3.
- out_ready  input  1  downstream accepts a beat this cycle.
- gnt  output  4  one-hot grant; all zero when idle.
- sel  output  2  mux select; 0..3 = requester index (sel[1] is the MSB).
- dout  output  WIDTH  muxed data = din[sel] while granted, else 0.
- dout_valid  output  1  beat offered to downstream.

Behaviour:
- Reset, synchronous, rst_n=0 at a clock edge:
  - state=IDLE, gnt=0, sel=0, dout_valid=0, beat count=0.
  - last_winner=3, so requester 0 has top priority after reset.
  - Reset asserted mid-burst drops the grant at that edge; no further beat is offered.
- States: IDLE and GRANT. State, sel, gnt, count and last_winner are registered.
- IDLE:
  - If req!=0, pick the first set req bit scanning last_winner+1, +2, +3, +4 (mod 4).
  - Next cycle: state=GRANT, sel=winner, gnt=onehot(winner), count=0.
  - If req==0, stay in IDLE.
  - Latency: req sampled high at edge N gives gnt high after edge N (cycle N+1).
- GRANT:
  - dout_valid = req[sel] (combinational); dout = din[sel] (combinational 4:1 mux).
  - Transfer = dout_valid & out_ready.
  - On transfer, count increments.
  - If the transfer makes count==MAX_BURST: go to IDLE, last_winner=sel.
  - If req[sel]==0 at the edge: go to IDLE, last_winner=sel, even if zero beats were transferred.
  - out_ready low: hold sel, gnt and count; no timeout.
- Re-arbitration always passes through exactly one IDLE cycle (gnt=0, dout_valid=0). Maximum grant-to-grant gap is 1 idle cycle.
- Simultaneous events:
  - Last-beat transfer and req[sel] drop in the same cycle: single exit to IDLE, last_winner=sel.
  - A requester that loses arbitration keeps req high; no request is ever lost.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0... Each grant lasts MAX_BURST beats when out_ready=1.
- Wrap-around: last_winner=3 scans 0,1,2,3. The count register is wide enough for MAX_BURST and never overflows, because it exits at equality.
- gnt is always one-hot or zero. gnt is nonzero only in GRANT.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=0, ST_GRANT=1.
  - SEL_W=2 and N_REQ=4.
- Sub-module rr_pick4: purely combinational.
  - Inputs: req[3:0], last[1:0].
  - Outputs: winner[1:0], any.
  - Instantiated once.
- The data mux is inlined as a case on sel.

Test Plan:
- Reset priority: rst_n=0 for 2 cycles, then req=4'b1010, out_ready=1 → gnt=4'b0010 and sel=1 one cycle later; 4 beats of din1; then one IDLE cycle; then gnt=4'b1000.
- Full rotation: req=4'b1111 held, out_ready=1, MAX_BURST=4 → sel sequence 0,1,2,3,0. Each grant is 4 dout_valid beats separated by exactly 1 idle cycle.
- Early release: req=4'b0001; drop req[0] after 2 transfers → IDLE next cycle, count=2 discarded. Then req=4'b0011 → gnt=4'b0010 (requester 1 goes next).
- Backpressure: granted to requester 2, out_ready toggles 1,0,0,1,1,1 → exactly 4 transfers counted, sel=2 stable throughout, exit after the 4th transfer.
- Reset mid-burst: grant to requester 3, rst_n=0 after 1 beat → gnt=0, dout_valid=0, sel=0 at the next edge. After release with req=4'b1000 → gnt=4'b1000 again.
- Simultaneous exit: on the 4th beat, req[sel] also drops → single IDLE cycle, last_winner=sel, no extra beat offered.
